l2_arbiter: RTL

//  Shares the single L2 cache port between the L1 instruction cache and the L1 data cache.

---
 rtl/l2_arbiter_if.sv | 30 +++
 rtl/l2_arbiter.sv | 53 +++++
 2 files changed

// File: rtl/l2_arbiter_if.sv
// l2_arbiter_if: L1 I/D miss ports and the shared L2 port seen by the arbiter
interface l2_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic              i_resp;
  logic [LINE_W-1:0] i_rdata;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic              d_resp;
  logic [LINE_W-1:0] d_rdata;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_address;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;
  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, l2_rdata, l2_resp,
    output i_resp, i_rdata, d_resp, d_rdata, l2_read, l2_write, l2_address, l2_wdata
  );
  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, l2_rdata, l2_resp,
    input  i_resp, i_rdata, d_resp, d_rdata, l2_read, l2_write, l2_address, l2_wdata
  );
endinterface

// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin sharing of the L2 port between the L1 I-cache and D-cache
module l2_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  l2_arbiter_if.slave      bus,
  output logic [CNT_W-1:0] contention_cnt
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  state_t            state, state_n;
  logic              last_d, d_req, grant_i, grant_d, done, wait_inc;
  logic              hold_write;
  logic [ADDR_W-1:0] hold_addr;
  logic [LINE_W-1:0] hold_wdata;
  always_comb begin
    d_req    = bus.d_read || bus.d_write;
    grant_i  = bus.i_read && (!d_req || last_d);
    grant_d  = d_req && !grant_i;
    done     = state != IDLE && bus.l2_resp;
    state_n  = state == IDLE ? (grant_i ? SERVE_I : grant_d ? SERVE_D : IDLE) : done ? IDLE : state;
    wait_inc = state == IDLE ? bus.i_read && d_req : state == SERVE_I ? d_req : bus.i_read;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      last_d         <= 1'b1;
      hold_write     <= 1'b0;
      hold_addr      <= '0;
      hold_wdata     <= '0;
      contention_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && (grant_i || grant_d)) begin
        hold_addr  <= grant_i ? bus.i_address : bus.d_address;
        hold_wdata <= grant_i ? '0 : bus.d_wdata;
        hold_write <= grant_d && bus.d_write;
      end
      if (done) last_d <= state == SERVE_D;
      if (wait_inc && !(&contention_cnt)) contention_cnt <= contention_cnt + 1'b1;
    end
  end
  assign bus.l2_read    = state != IDLE && !hold_write;
  assign bus.l2_write   = state != IDLE && hold_write;
  assign bus.l2_address = hold_addr;
  assign bus.l2_wdata   = hold_wdata;
  assign bus.i_resp     = state == SERVE_I && bus.l2_resp;
  assign bus.d_resp     = state == SERVE_D && bus.l2_resp;
  assign bus.i_rdata    = bus.l2_rdata;
  assign bus.d_rdata    = bus.l2_rdata;
endmodule
